// File: rtl/bsg_profiler_counter_dumper.sv
`default_nettype none
// ============================================================================
// Module   : bsg_profiler_counter_dumper
// Brief    : Bank of saturating event counters with atomic snapshot and
//            valid/ready streaming read-out of the snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_profiler_counter_dumper #(
    parameter int els_p     = 32,
    parameter int width_p   = 32,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [els_p-1:0]     countme_i,
    input  logic                 dump_v_i,
    input  logic                 clear_i,
    output logic                 dump_ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    output logic [lg_els_lp-1:0] id_o,
    output logic                 last_o,
    input  logic                 ready_i
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    localparam logic [lg_els_lp-1:0] c_last_idx = lg_els_lp'(els_p - 1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [lg_els_lp-1:0]   r_idx;
    logic [lg_els_lp-1:0]   w_idx_next;
    logic                   w_accept;
    logic                   w_last;
    logic [width_p-1:0]     w_snap [els_p];

    assign dump_ready_o = (r_state == S_IDLE) & ~reset_i;
    assign w_accept     = dump_v_i & dump_ready_o;
    assign w_last       = (r_idx == c_last_idx);

    assign v_o    = (r_state == S_SEND) & ~reset_i;
    assign last_o = v_o & w_last;
    assign id_o   = r_idx;
    assign data_o = w_snap[r_idx];

    // Each counter owns its live and snapshot register; snapshot captures the
    // pre-increment value of the accept cycle.
    generate
        for (genvar k = 0; k < els_p; k++) begin : g_counter
            logic [width_p-1:0] r_live;
            logic [width_p-1:0] r_snap;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_live <= '0;
                    r_snap <= '0;
                end else begin
                    if (w_accept) begin
                        r_snap <= r_live;
                    end
                    if (w_accept && clear_i) begin
                        r_live <= {{(width_p-1){1'b0}}, countme_i[k]};
                    end else if (countme_i[k] && !(&r_live)) begin
                        r_live <= r_live + {{(width_p-1){1'b0}}, 1'b1};
                    end
                end
            end

            assign w_snap[k] = r_snap;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SEND;
                    w_idx_next   = '0;
                end
            end
            S_SEND: begin
                if (ready_i) begin
                    if (w_last) begin
                        w_state_next = S_IDLE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + lg_els_lp'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_profiler_counter_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_profiler_counter_dumper
// Brief    : Directed scoreboard bench for the profiler counter dumper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_profiler_counter_dumper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic [31:0] countme_i;
    logic        dump_v_i, clear_i, ready_i;
    logic        dump_ready_o, v_o, last_o;
    logic [31:0] data_o;
    logic [4:0]  id_o;

    logic [31:0] s_countme;
    logic        s_dump_v, s_clear, s_ready;
    logic        s_dump_ready, s_v, s_last;
    logic [3:0]  s_data;
    logic [4:0]  s_id;

    bsg_profiler_counter_dumper #(.els_p(32), .width_p(32)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .countme_i(countme_i),
        .dump_v_i(dump_v_i), .clear_i(clear_i), .dump_ready_o(dump_ready_o),
        .v_o(v_o), .data_o(data_o), .id_o(id_o), .last_o(last_o),
        .ready_i(ready_i)
    );

    bsg_profiler_counter_dumper #(.els_p(32), .width_p(4)) u_sat (
        .clk_i(clk), .reset_i(reset_i), .countme_i(s_countme),
        .dump_v_i(s_dump_v), .clear_i(s_clear), .dump_ready_o(s_dump_ready),
        .v_o(s_v), .data_o(s_data), .id_o(s_id), .last_o(s_last),
        .ready_i(s_ready)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        last;
    } entry_t;

    entry_t      q[$];
    logic [31:0] live [32];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic b);
        return (b && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    // One stimulus cycle while the DUT is idle; a dump pushes the expected stream.
    task automatic cycle(input logic [31:0] cm, input logic dv, input logic clr);
        @(negedge clk);
        if (dv) check("dump_ready_at_accept", {31'd0, dump_ready_o}, 32'd1);
        countme_i = cm; dump_v_i = dv; clear_i = clr; ready_i = 1'b1;
        if (dv) begin
            for (int k = 0; k < 32; k++) q.push_back('{k, live[k], (k == 31)});
        end
        for (int k = 0; k < 32; k++) live[k] = (dv && clr) ? {31'd0, cm[k]} : sat_inc(live[k], cm[k]);
        @(posedge clk);
    endtask

    // mode 0: ready high; mode 1: ready 1,0,0 pattern + events + ignored dumps;
    // mode 2: reset asserted when entry 10 is presented.
    task automatic drain(input int mode);
        int n = 0;
        int budget = 400;
        logic rdy;
        logic [31:0] cm;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            check("v_o", {31'd0, v_o}, 32'd1);
            check("id_o", {27'd0, id_o}, q[0].id);
            check("data_o", data_o, q[0].data);
            check("last_o", {31'd0, last_o}, {31'd0, q[0].last});
            check("dump_ready_in_send", {31'd0, dump_ready_o}, 32'd0);
            if (mode == 2 && q[0].id == 10) begin
                reset_i = 1'b1; countme_i = '0; dump_v_i = 1'b0; clear_i = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("v_o_after_reset", {31'd0, v_o}, 32'd0);
                check("dump_ready_in_reset", {31'd0, dump_ready_o}, 32'd0);
                reset_i = 1'b0;
                q.delete();
                for (int k = 0; k < 32; k++) live[k] = '0;
            end else begin
                rdy = (mode == 1) ? (n % 3 == 0) : 1'b1;
                cm  = (mode == 1) ? (32'd1 << (n % 32)) : 32'd0;
                ready_i = rdy; countme_i = cm;
                dump_v_i = (mode == 1) && (n % 3 == 1);
                clear_i  = dump_v_i;
                for (int k = 0; k < 32; k++) live[k] = sat_inc(live[k], cm[k]);
                @(posedge clk);
                if (rdy) void'(q.pop_front());
                n++;
                budget--;
            end
        end
        if (budget == 0) check("drain_timeout", q.size(), 32'd0);
        @(negedge clk);
        check("dump_ready_after_stream", {31'd0, dump_ready_o}, 32'd1);
        check("v_o_after_stream", {31'd0, v_o}, 32'd0);
        countme_i = '0; dump_v_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b1; countme_i = '0; dump_v_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0;
        s_countme = '0; s_dump_v = 1'b0; s_clear = 1'b0; s_ready = 1'b0;
        for (int k = 0; k < 32; k++) live[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dump_ready", {31'd0, dump_ready_o}, 32'd0);
        check("reset_v_o", {31'd0, v_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);
        check("idle_dump_ready", {31'd0, dump_ready_o}, 32'd1);
        check("idle_v_o", {31'd0, v_o}, 32'd0);
        check("idle_last_o", {31'd0, last_o}, 32'd0);

        // Basic dump without clear, then clear dump, then empty dump
        repeat (5) cycle(32'h8, 1'b0, 1'b0);
        repeat (2) cycle(32'h1, 1'b0, 1'b0);
        check("model_id0", live[0], 32'd2);
        check("model_id3", live[3], 32'd5);
        cycle(32'h0, 1'b1, 1'b0);
        drain(0);
        cycle(32'h0, 1'b1, 1'b1);
        drain(0);
        cycle(32'h0, 1'b1, 1'b0);
        drain(0);

        // Event in the accept cycle with clear lands in the new epoch
        repeat (3) cycle(32'h4, 1'b0, 1'b0);
        cycle(32'h4, 1'b1, 1'b1);
        drain(0);
        cycle(32'h0, 1'b1, 1'b0);
        drain(0);

        // Back-pressure, counting during SEND, ignored dump requests
        repeat (4) cycle(32'h80, 1'b0, 1'b0);
        cycle(32'h0, 1'b1, 1'b0);
        drain(1);
        cycle(32'h0, 1'b1, 1'b1);
        drain(0);

        // Reset mid-stream, then a dump of all zeros
        repeat (2) cycle(32'h20, 1'b0, 1'b0);
        cycle(32'h0, 1'b1, 1'b0);
        drain(2);
        cycle(32'h0, 1'b1, 1'b0);
        drain(0);

        // Saturation on the 4-bit instance
        @(negedge clk);
        s_countme = 32'h2;
        repeat (20) @(negedge clk);
        check("sat_dump_ready", {31'd0, s_dump_ready}, 32'd1);
        s_countme = '0; s_dump_v = 1'b1;
        @(negedge clk);
        s_dump_v = 1'b0; s_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("sat_v", {31'd0, s_v}, 32'd1);
            check("sat_id", {27'd0, s_id}, i);
            check("sat_data", {28'd0, s_data}, (i == 1) ? 32'd15 : 32'd0);
            check("sat_last", {31'd0, s_last}, (i == 31) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        check("sat_ready_after", {31'd0, s_dump_ready}, 32'd1);
        check("sat_v_after", {31'd0, s_v}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_profiler_counter_dumper.md
Name: bsg_profiler_counter_dumper

Overview:
- Bank of `els_p` saturating event counters, each incremented by a per-event strobe.
- On a dump request, snapshots all counters atomically and optionally clears them, then streams the snapshot one entry per transfer over a valid/ready interface.
- Synthesizable read-out end of the profiling flow: event sources increment, this block drains the counts to a host or logger.

Parameters:
- els_p, 32, number of counters/event inputs (>=2)
- width_p, 32, counter width in bits (>=2)
- lg_els_lp, `BSG_SAFE_CLOG2(els_p)`, derived: index width

Ports:
- clk_i  input  1  clock; all state updates on posedge
- reset_i  input  1  synchronous, active-high reset
- countme_i  input  els_p  bit k high in a cycle => counter k += 1 that cycle
- dump_v_i  input  1  dump request; accepted when dump_v_i & dump_ready_o
- clear_i  input  1  sampled with accepted dump; 1 => live counters restart from the event of that cycle
- dump_ready_o  output  1  high in IDLE only
- v_o  output  1  snapshot entry valid (SEND state)
- data_o  output  width_p  snapshot value of counter `id_o`
- id_o  output  lg_els_lp  index of current entry
- last_o  output  1  high with v_o when id_o == els_p-1
- ready_i  input  1  consumer ready; transfer = v_o & ready_i

Behaviour:
- Reset (synchronous, reset_i high at posedge):
  - all live and snapshot counters = 0, state = IDLE, index = 0
  - v_o = 0, last_o = 0, dump_ready_o = 1 (from the cycle after reset deasserts)
  - while reset_i is high: dump_ready_o = 0, v_o = 0
  - reset mid-dump aborts the stream immediately; no further entries are emitted
- Live counters: every cycle not in reset, live[k] <= sat(live[k] + countme_i[k]).
  - sat clamps at 2^width_p - 1: counter holds at max, no wrap.
  - Counting continues in all states, including during SEND.
- States:
  - IDLE: dump_ready_o = 1, v_o = 0. On dump accept:
    - snap[k] <= live[k] (pre-increment value of that cycle) for all k
    - if clear_i: live[k] <= countme_i[k]; else live[k] <= sat(live[k] + countme_i[k])
    - index <= 0, go to SEND
  - SEND: v_o = 1, dump_ready_o = 0, data_o = snap[index], id_o = index, last_o = (index == els_p-1).
    - On transfer with last_o: go to IDLE, index <= 0.
    - On transfer without last_o: index += 1.
    - No transfer: hold all outputs stable. v_o never drops without a transfer.
- dump_v_i in SEND is ignored; it is not queued.
- Latency:
  - First entry is valid the cycle after dump accept.
  - With ready_i held high, one entry per cycle: els_p transfer cycles.
  - dump_ready_o reasserts the cycle after the last transfer.
  - Back-to-back dump minimum period: els_p + 1 cycles.
- Events in the accept cycle:
  - With clear: counted in the new epoch only.
  - Without clear: in live only, not in the snapshot.
- snap registers change only on dump accept or reset.
- Outputs are registered-state driven; no combinational path from ready_i or dump_v_i to v_o or data_o.

Test Plan:
- Reset, countme_i[3] high 5 cycles, countme_i[0] high 2 cycles, dump clear_i=0, ready_i=1 -> 32 entries on consecutive cycles: id 0 = 2, id 3 = 5, others 0; last_o only with id 31; dump_ready_o high next cycle.
- Same as above, then dump again with clear_i=1, then a third dump with no events between -> second dump identical to first; third dump all zeros.
- width_p=4, countme_i[1] held high 20 cycles, dump -> id 1 = 15 (saturated), no wrap.
- countme_i[2] high in the accept cycle, clear_i=1; next dump -> first dump shows prior count; second dump id 2 = 1.
- ready_i toggled 1,0,0,1,... during SEND -> data_o/id_o stable while ready_i=0; all 32 entries delivered in order with no drop or duplicate; dump_v_i pulses during SEND ignored.
- reset_i asserted at id 10 mid-stream -> v_o = 0 next cycle; afterwards a dump returns all zeros starting at id 0.
